// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, LSB-first data, optional parity, stop).
//
// Ports:
//   CLK        oversampling clock (Prescale x baud)
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high, already synchronised
//   Prescale   oversampling ratio (8/16/32; anything else behaves as 8)
//   par_en     frame carries a parity bit
//   par_typ    0 = even parity, 1 = odd parity
//   P_DATA     last correctly received word
//   data_valid one-cycle pulse when P_DATA is loaded with a good frame
//   par_err    one-cycle pulse on parity mismatch
//   stp_err    one-cycle pulse when the stop bit is sampled low
//
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
// around mid-bit. Frame timing is identical in both builds.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  frame_bad;

  logic [CNT_W-1:0]      half_c;
  logic                  last_edge_c;
  logic                  bit_c;

  // Unsupported ratios fall back to 8 so the counters always wrap sanely.
  function automatic logic [CNT_W-1:0] decode_prescale(input logic [5:0] p);
    case (p)
      6'd16:   decode_prescale = CNT_W'(16);
      6'd32:   decode_prescale = CNT_W'(32);
      default: decode_prescale = CNT_W'(8);
    endcase
  endfunction

  assign half_c      = prescale_q >> 1;
  assign last_edge_c = (edge_cnt == (prescale_q - CNT_W'(1)));

`ifdef UART_RX_MAJORITY_EN
  // Three samples straddling mid-bit; the vote is settled well before the
  // end-of-bit decision point.
  logic [2:0] votes;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      votes <= 3'b111;
    end else begin
      if (edge_cnt == (half_c - CNT_W'(1))) votes[0] <= RX_IN;
      if (edge_cnt == half_c)               votes[1] <= RX_IN;
      if (edge_cnt == (half_c + CNT_W'(1))) votes[2] <= RX_IN;
    end
  end

  assign bit_c = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
`else
  // Single mid-bit sample.
  logic sample_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sample_q <= 1'b1;
    end else if (edge_cnt == half_c) begin
      sample_q <= RX_IN;
    end
  end

  assign bit_c = sample_q;
`endif

  // Frame FSM; decisions are taken on the last oversample of each bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      prescale_q <= CNT_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      frame_bad  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      case (state)
        IDLE: begin
          edge_cnt  <= '0;
          bit_cnt   <= '0;
          frame_bad <= 1'b0;
          // Start-detect cycle is oversample 0 of the start bit.
          if (!RX_IN) begin
            state      <= START;
            edge_cnt   <= CNT_W'(1);
            prescale_q <= decode_prescale(Prescale);
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
          end
        end

        default: begin
          edge_cnt <= last_edge_c ? '0 : edge_cnt + CNT_W'(1);
          if (last_edge_c) begin
            case (state)
              START: state <= bit_c ? IDLE : DATA;

              DATA: begin
                shift_q <= {bit_c, shift_q[DATA_WIDTH-1:1]};
                if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt <= '0;
                  state   <= par_en_q ? PARITY : STOP;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                end
              end

              PARITY: begin
                if (bit_c != ((^shift_q) ^ par_typ_q)) begin
                  par_err   <= 1'b1;
                  frame_bad <= 1'b1;
                end
                state <= STOP;
              end

              STOP: begin
                state <= IDLE;
                if (!bit_c) begin
                  stp_err <= 1'b1;
                end else if (!frame_bad) begin
                  P_DATA     <= shift_q;
                  data_valid <= 1'b1;
                end
              end

              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a frame-level expectation model.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  // Expected pulses keyed by absolute cycle number.
  bit         exp_dv[int];
  bit         exp_pe[int];
  bit         exp_se[int];
  logic [7:0] exp_word[int];
  logic [7:0] model_pdata = 8'h00;
  bit         chk_en = 1'b0;

  int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
  int         last_dv = -1, last_pe = -1, last_se = -1;
  logic [7:0] dv_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of every output against the model.
  bit dv_e, pe_e, se_e;
  always @(negedge CLK) begin
    if (chk_en) begin
      dv_e = exp_dv.exists(cyc);
      pe_e = exp_pe.exists(cyc);
      se_e = exp_se.exists(cyc);
      if (dv_e) model_pdata = exp_word[cyc];
      check("data_valid", 32'(data_valid), 32'(dv_e));
      check("par_err",    32'(par_err),    32'(pe_e));
      check("stp_err",    32'(stp_err),    32'(se_e));
      check("P_DATA",     32'(P_DATA),     32'(model_pdata));
      if (data_valid) begin dv_cnt++; last_dv = cyc; dv_words.push_back(P_DATA); end
      if (par_err)    begin pe_cnt++; last_pe = cyc; end
      if (stp_err)    begin se_cnt++; last_se = cyc; end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one frame; config is scrambled after start to exercise latching.
  // gl: cycle offset of a one-cycle line inversion (-1 none).
  // rst_at: cycle offset at which reset is asserted and the frame abandoned.
  task automatic send_frame(input logic [5:0] presc, input logic [7:0] d,
                            input bit pen, input bit ptyp, input bit pbit, input bit sbit,
                            input int gl, input int rst_at, output int t0);
    int         pe, n;
    logic [7:0] w;
    bit         bits[$];
    bit         perr;
    pe = (presc == 6'd16 || presc == 6'd32) ? int'(presc) : 8;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(sbit);
    n = bits.size();
    w = d;
`ifndef UART_RX_MAJORITY_EN
    // A single sampler sees an inversion only if it lands on mid-bit.
    if (gl >= 0 && (gl / pe) >= 1 && (gl / pe) <= 8 && (gl % pe) == pe / 2)
      w[(gl / pe) - 1] = ~w[(gl / pe) - 1];
`endif
    perr = pen && (pbit != ((^w) ^ ptyp));
    t0 = -1;
    for (int c = 0; c < n * pe; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        t0 = cyc;
        Prescale = presc; par_en = pen; par_typ = ptyp;
        if (perr) exp_pe[t0 + 10 * pe] = 1'b1;
        if (!sbit) exp_se[t0 + n * pe] = 1'b1;
        else if (!perr) begin
          exp_dv[t0 + n * pe]   = 1'b1;
          exp_word[t0 + n * pe] = w;
        end
      end
      if (c == 3 * pe) begin
        Prescale = ~presc; par_en = ~pen; par_typ = ~ptyp;
      end
      RX_IN = bits[c / pe] ^ (c == gl);
      if (c == rst_at) begin
        #2;
        RST = 1'b0;
        exp_dv.delete(); exp_pe.delete(); exp_se.delete(); exp_word.delete();
        model_pdata = 8'h00;
        #1;
        check("rst_P_DATA",     32'(P_DATA),     32'h00);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_par_err",    32'(par_err),    32'h0);
        check("rst_stp_err",    32'(stp_err),    32'h0);
        break;
      end
    end
  endtask

  int t0, ta, tb, d0, p0, s0, w0;

  initial begin
    CLK = 1'b0; RST = 1'b0; RX_IN = 1'b1;
    Prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_P_DATA",     32'(P_DATA),     32'h00);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_par_err",    32'(par_err),    32'h0);
    check("reset_stp_err",    32'(stp_err),    32'h0);
    RST = 1'b1;
    chk_en = 1'b1;
    idle(4);

    // P=8, no parity, 0xA5.
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    send_frame(6'd8, 8'hA5, 0, 0, 0, 1, -1, -1, t0);
    idle(3);
    check("t1_dv_cycle", 32'(last_dv - t0), 32'd80);
    check("t1_P_DATA",   32'(P_DATA),       32'hA5);
    check("t1_counts",   32'((dv_cnt - d0) * 100 + (pe_cnt - p0) * 10 + (se_cnt - s0)), 32'd100);

    // P=16, even parity: good frame then parity error.
    send_frame(6'd16, 8'h3C, 1, 0, 0, 1, -1, -1, t0);
    idle(3);
    check("t2a_dv_cycle", 32'(last_dv - t0), 32'd176);
    check("t2a_P_DATA",   32'(P_DATA),       32'h3C);
    d0 = dv_cnt;
    send_frame(6'd16, 8'h3C, 1, 0, 1, 1, -1, -1, t0);
    idle(3);
    check("t2b_pe_cycle", 32'(last_pe - t0), 32'd160);
    check("t2b_no_dv",    32'(dv_cnt - d0),  32'd0);
    check("t2b_P_DATA",   32'(P_DATA),       32'h3C);

    // P=32, odd parity correct, stop low.
    d0 = dv_cnt; p0 = pe_cnt;
    send_frame(6'd32, 8'h01, 1, 1, 0, 0, -1, -1, t0);
    idle(3);
    check("t3_se_cycle", 32'(last_se - t0), 32'd352);
    check("t3_no_pe",    32'(pe_cnt - p0),  32'd0);
    check("t3_no_dv",    32'(dv_cnt - d0),  32'd0);

    // Start glitch, then two back-to-back frames.
    d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
    Prescale = 6'd8; par_en = 1'b0;
    repeat (2) begin @(negedge CLK); RX_IN = 1'b0; end
    idle(12);
    check("glitch_no_pulses", 32'((dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0)), 32'd0);
    w0 = dv_words.size();
    send_frame(6'd8, 8'h55, 0, 0, 0, 1, -1, -1, ta);
    send_frame(6'd8, 8'hAA, 0, 0, 0, 1, -1, -1, tb);
    idle(3);
    check("b2b_gap",   32'(tb - ta),        32'd80);
    check("b2b_count", 32'(dv_cnt - d0),    32'd2);
    if (dv_words.size() >= w0 + 2) begin
      check("b2b_word0", 32'(dv_words[w0]),     32'h55);
      check("b2b_word1", 32'(dv_words[w0 + 1]), 32'hAA);
    end
    check("b2b_last_dv", 32'(last_dv - tb), 32'd80);

    // Line break: two stop errors, immediate restart, no data.
    d0 = dv_cnt; s0 = se_cnt;
    @(negedge CLK);
    t0 = cyc; RX_IN = 1'b0; Prescale = 6'd8; par_en = 1'b0;
    exp_se[t0 + 80]  = 1'b1;
    exp_se[t0 + 160] = 1'b1;
    repeat (159) begin @(negedge CLK); RX_IN = 1'b0; end
    idle(20);
    check("break_se_count", 32'(se_cnt - s0),   32'd2);
    check("break_last_se",  32'(last_se - t0),  32'd160);
    check("break_no_dv",    32'(dv_cnt - d0),   32'd0);

    // Reset mid-frame, then a clean 0x81 frame.
    send_frame(6'd8, 8'h3C, 0, 0, 0, 1, -1, 40, t0);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    idle(10);
    send_frame(6'd8, 8'h81, 0, 0, 0, 1, -1, -1, t0);
    idle(3);
    check("post_rst_dv_cycle", 32'(last_dv - t0), 32'd80);
    check("post_rst_P_DATA",   32'(P_DATA),       32'h81);

    // Illegal prescale behaves as 8.
    send_frame(6'd12, 8'h96, 0, 0, 0, 1, -1, -1, t0);
    idle(3);
    check("illegal_ps_dv_cycle", 32'(last_dv - t0), 32'd80);
    check("illegal_ps_P_DATA",   32'(P_DATA),       32'h96);

    // One-cycle inversion at mid-bit of data bit 3.
    send_frame(6'd16, 8'h00, 0, 0, 0, 1, 72, -1, t0);
    idle(3);
`ifdef UART_RX_MAJORITY_EN
    check("glitch_bit3_P_DATA", 32'(P_DATA), 32'h00);
`else
    check("glitch_bit3_P_DATA", 32'(P_DATA), 32'h08);
`endif
    check("glitch_bit3_dv_cycle", 32'(last_dv - t0), 32'd160);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream stage of the UART transmitter.
- Consumes the serial line (idle high), oversampled by a programmable prescale.
- Recovers start, data (LSB first), optional parity and stop bits.
- Presents a parallel word with a one-cycle valid pulse plus per-frame parity/stop error pulses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame

Ports:
CLK  input  1  receiver oversampling clock (Prescale x baud)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high; already synchronised upstream
Prescale  input  6  oversampling ratio; legal values 8, 16, 32
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received word
data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame
par_err  output  1  one-cycle pulse: parity mismatch in current frame
stp_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (RST low, asynchronous): FSM to IDLE, counters cleared, P_DATA=0, data_valid=0, par_err=0, stp_err=0. Reset mid-frame discards the frame with no pulses.
- Latched config: Prescale, par_en and par_typ are latched on start detect and held for the whole frame; mid-frame changes are ignored.
- Illegal Prescale: values other than 8/16/32 behave as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit; bit_cnt counts data bits 0..DATA_WIDTH-1.
  - The cycle of start detect is edge_cnt=0 of the start bit.
- Sampling: the bit value is the sample at edge_cnt=P/2 (see optional feature). Decisions are taken at edge_cnt=P-1 of each bit.
- FSM states:
  - IDLE: edge_cnt held 0. RX_IN==0 -> START.
  - START: at edge_cnt=P-1, sampled 1 (glitch) -> IDLE with no output pulses; sampled 0 -> DATA.
  - DATA: shift the sample in LSB-first at edge_cnt=P-1. After bit DATA_WIDTH-1 -> PARITY if par_en, else STOP.
  - PARITY: at edge_cnt=P-1, compare the sample with the expected parity (XOR of data, inverted if par_typ=1). Mismatch -> par_err=1 next cycle and the frame is flagged bad. Always -> STOP.
  - STOP: at edge_cnt=P-1 -> IDLE.
    - Sample 0 -> stp_err=1 next cycle.
    - Sample 1 and frame not flagged bad -> P_DATA loaded and data_valid=1 next cycle.
- Output timing: with N = 2+DATA_WIDTH+par_en bits per frame, data_valid/stp_err assert in cycle N*P relative to start-detect cycle 0.
  - The pulse cycle is IDLE, so a new start bit may be detected in that same cycle (back-to-back frames, no gap required).
- Bad frames: data_valid is never asserted for a frame with par_err or stp_err; P_DATA keeps its previous value. par_err and stp_err can both fire for one frame (different cycles).
- Line break (RX_IN held low): every frame ends with stp_err and the receiver restarts immediately; no data_valid.
- All outputs are registered.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: three samples are taken at edge_cnt=P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, available from edge_cnt=P/2+2. It applies to start, data, parity and stop bits alike, including glitch rejection in START.
- Undefined: single sample at edge_cnt=P/2, with no vote logic and no extra registers.
- Frame timing and pulse cycles are identical in both builds.

Test Plan:
- Prescale=8, par_en=0, send 0xA5 (LSB first), stop=1 -> data_valid pulse at cycle 80, P_DATA=0xA5, par_err=stp_err=0.
- Prescale=16, par_en=1, par_typ=0, send 0x3C with parity 0, then 0x3C with parity 1 -> first: data_valid at cycle 176, P_DATA=0x3C. Second: par_err pulse at cycle 160, no data_valid, P_DATA stays 0x3C.
- Prescale=32, par_en=1, par_typ=1, send 0x01 with parity 0 then stop=0 -> no par_err, stp_err pulse at cycle 352, no data_valid.
- Prescale=8: 2-cycle low glitch on an idle line -> returns to IDLE after 8 cycles with no pulses. Then send frames 0x55 and 0xAA back-to-back, zero idle gap -> two data_valid pulses 80 cycles apart, P_DATA=0x55 then 0xAA.
- RST driven low at cycle 40 of a Prescale=8 frame -> all outputs 0 immediately. The next complete 0x81 frame -> data_valid with P_DATA=0x81.
- UART_RX_MAJORITY_EN defined, Prescale=16: a single-cycle inverted pulse at edge_cnt=8 of data bit 3 of 0x00 -> P_DATA=0x00. Without the macro, the same stimulus gives P_DATA=0x08.
